lvds_error_injector: RTL

// - Parametrised link-debug error injector between the LVDS transceiver symbol stream and the

---
 rtl/lvds_error_injector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lvds_error_injector.sv
// Purpose: link-debug error injector; XORs a mask into a chosen word after a trigger symbol.
// Latency: fixed 2 cycles from i_data/i_valid to o_data/o_valid, injected or not.
// Backpressure: none; the word stream is qualified by i_valid only and is never stalled.
module lvds_error_injector #(
    parameter int DATA_W = 9,
    parameter int OFS_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              i_sys_clk_120,
    input  logic              i_sys_arst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_done_ack,
    input  logic [DATA_W-1:0] i_cfg_trig,
    input  logic [OFS_W-1:0]  i_cfg_offset,
    input  logic [DATA_W-1:0] i_cfg_mask,
    input  logic [CNT_W-1:0]  i_cfg_count,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_inj_pulse,
    output logic [CNT_W-1:0]  o_inj_cnt,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        OFFSET = 2'd2
    } state_t;

    state_t              state;
    logic                v1;
    logic [DATA_W-1:0]   d1;
    logic [DATA_W-1:0]   trig_q;
    logic [DATA_W-1:0]   mask_q;
    logic [OFS_W-1:0]    ofs_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OFS_W-1:0]    ofs_cnt;
    logic [CNT_W-1:0]    inj_cnt;
    logic                done_q;

    logic                trig_hit;
    logic                inj;
    logic                start_acc;
    logic                done_evt;
    logic [CNT_W-1:0]    inj_cnt_nxt;

    assign trig_hit  = v1 && (d1 == trig_q);
    // i_stop outranks i_start even in IDLE, so a coincident pair never arms.
    assign start_acc = i_start && !i_stop && (state == IDLE);

    // Decide whether the stage1 word is the target; a same-cycle stop suppresses it.
    always_comb begin
        inj = 1'b0;
        case (state)
            ARMED:   inj = trig_hit && (ofs_q == '0);
            OFFSET:  inj = v1 && (ofs_cnt == OFS_W'(1));
            default: inj = 1'b0;
        endcase
        if (i_stop) begin
            inj = 1'b0;
        end
    end

    // Saturating increment of the injected-word counter and the run-complete condition.
    always_comb begin
        inj_cnt_nxt = (&inj_cnt) ? inj_cnt : inj_cnt + CNT_W'(1);
        done_evt    = inj && (cnt_q != '0) && (inj_cnt_nxt == cnt_q);
    end

    // Two-stage datapath: stage1 captures the raw word, stage2 applies the mask.
    always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
        if (!i_sys_arst_n) begin
            v1          <= 1'b0;
            d1          <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_inj_pulse <= 1'b0;
        end else begin
            v1          <= i_valid;
            d1          <= i_data;
            o_valid     <= v1;
            o_data      <= d1 ^ (inj ? mask_q : '0);
            o_inj_pulse <= inj;
        end
    end

    // Run control FSM: arm on start, track the trigger offset, count injections.
    always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
        if (!i_sys_arst_n) begin
            state   <= IDLE;
            trig_q  <= '0;
            mask_q  <= '0;
            ofs_q   <= '0;
            cnt_q   <= '0;
            ofs_cnt <= '0;
            inj_cnt <= '0;
        end else if (i_stop) begin
            state   <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        trig_q  <= i_cfg_trig;
                        mask_q  <= i_cfg_mask;
                        ofs_q   <= i_cfg_offset;
                        cnt_q   <= i_cfg_count;
                        ofs_cnt <= '0;
                        inj_cnt <= '0;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig_hit && (ofs_q != '0)) begin
                        ofs_cnt <= ofs_q;
                        state   <= OFFSET;
                    end
                end
                OFFSET: begin
                    // Triggers seen here are ordinary words: no re-trigger.
                    if (v1) begin
                        if (ofs_cnt == OFS_W'(1)) begin
                            state <= ARMED;
                        end else begin
                            ofs_cnt <= ofs_cnt - OFS_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (inj) begin
                inj_cnt <= inj_cnt_nxt;
                if (done_evt) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Sticky done flag; a done event beats a coincident acknowledge.
    always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
        if (!i_sys_arst_n) begin
            done_q <= 1'b0;
        end else if (done_evt) begin
            done_q <= 1'b1;
        end else if (i_done_ack || start_acc) begin
            done_q <= 1'b0;
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_inj_cnt = inj_cnt;
    assign o_done    = done_q;

endmodule
